// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN weight-load path: sizes, loader state
// encoding and the core's power-on weight image.
package bnn_pkg;

  localparam int NUM_NEURONS = 12;
  localparam int NIBBLE_W    = 4;
  localparam int WEIGHT_W    = 8;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WAIT,
    LD_SEND_LO,
    LD_SEND_HI,
    LD_DONE
  } bnn_ld_state_t;

  // Weight bytes the core holds after reset, neuron 0 first.
  localparam logic [WEIGHT_W-1:0] DEFAULT_WEIGHTS [NUM_NEURONS] = '{
    8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h69, 8'h96,
    8'hA5, 8'h3C, 8'hE1, 8'h1E, 8'h7B, 8'hB7
  };

endpackage

// File: rtl/bnn_byte_fifo.sv
// Small synchronous FIFO with show-ahead read data (dout is the head entry
// whenever empty is low). Pointers and occupancy clear asynchronously.
module bnn_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bnn_weight_streamer.sv
// Host-side transmitter for the BNN weight-load bus: buffers weight bytes and
// sends each as low nibble then high nibble under the core's enable.
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDX_W       = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          s_valid,
  input  logic [bnn_pkg::WEIGHT_W-1:0]  s_data,
  output logic                          s_ready,
  input  logic                          tgt_ena,
  output logic                          load_en,
  output logic [bnn_pkg::NIBBLE_W-1:0]  nibble,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_W-1:0]              neuron_idx
);

  import bnn_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  bnn_ld_state_t        state;
  bnn_ld_state_t        next_state;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WEIGHT_W-1:0]  fifo_dout;
  logic [CNT_W-1:0]     fifo_count;
  logic                 unused_fifo_count;
  logic [WEIGHT_W-1:0]  weight;
  logic                 clr_idx;
  logic                 inc_idx;
  logic                 load_en_d;
  logic [NIBBLE_W-1:0]  nibble_d;
  logic                 busy_d;
  logic                 done_d;

  assign s_ready           = !fifo_full;
  assign fifo_push         = s_valid && s_ready;
  assign unused_fifo_count = ^fifo_count;

  bnn_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WEIGHT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LD_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    clr_idx    = 1'b0;
    inc_idx    = 1'b0;
    unique case (state)
      LD_IDLE: begin
        if (start) begin
          clr_idx = 1'b1;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            next_state = LD_SEND_LO;
          end else begin
            next_state = LD_WAIT;
          end
        end
      end
      LD_WAIT: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = LD_SEND_LO;
        end
      end
      LD_SEND_LO: begin
        if (tgt_ena) next_state = LD_SEND_HI;
      end
      LD_SEND_HI: begin
        // The core only sees a nibble when enabled, so the hi phase may not
        // be abandoned early: leaving here always follows a consumed nibble.
        if (tgt_ena) begin
          if (neuron_idx == LAST_IDX) begin
            next_state = LD_DONE;
          end else begin
            inc_idx = 1'b1;
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              next_state = LD_SEND_LO;
            end else begin
              next_state = LD_WAIT;
            end
          end
        end
      end
      LD_DONE:  next_state = LD_IDLE;
      default:  next_state = LD_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register without a combinational path to the core.
  always_comb begin
    load_en_d = (next_state == LD_SEND_LO) || (next_state == LD_SEND_HI);
    nibble_d  = '0;
    busy_d    = (next_state != LD_IDLE);
    done_d    = (next_state == LD_DONE);
    if (next_state == LD_SEND_LO) begin
      nibble_d = fifo_pop ? fifo_dout[NIBBLE_W-1:0] : weight[NIBBLE_W-1:0];
    end else if (next_state == LD_SEND_HI) begin
      nibble_d = weight[WEIGHT_W-1:NIBBLE_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_en    <= 1'b0;
      nibble     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      neuron_idx <= '0;
    end else begin
      load_en <= load_en_d;
      nibble  <= nibble_d;
      busy    <= busy_d;
      done    <= done_d;
      if (clr_idx)      neuron_idx <= '0;
      else if (inc_idx) neuron_idx <= neuron_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_pop) weight <= fifo_dout;
  end

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Scoreboard bench for bnn_weight_streamer with a behavioural model of the
// core's nibble receiver and weight register.
module tb_bnn_weight_streamer;
  import bnn_pkg::*;

  localparam int N     = NUM_NEURONS;
  localparam int IDX_W = 5;

  localparam logic [7:0] TBL_A [N] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h12, 8'h34,
                                       8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  localparam logic [7:0] TBL_C [N] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h96,
                                       8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
  localparam logic [7:0] TBL_D [N] = '{8'h01, 8'h02, 8'h03, 8'h81, 8'h45, 8'h67,
                                       8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h10, 8'h32};
  localparam logic [7:0] TBL_E [N] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5,
                                       8'hC6, 8'h7E, 8'hC8, 8'hC9, 8'hCA, 8'hCB};
  localparam logic [7:0] TBL_F [N] = '{8'h0D, 8'h1D, 8'h2D, 8'h3D, 8'h4D, 8'h5D,
                                       8'h6D, 8'h7D, 8'h8D, 8'h9D, 8'hAD, 8'hBD};

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_ready;
  logic             tgt_ena;
  logic             load_en;
  logic [3:0]       nibble;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] neuron_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q [$];
  logic [7:0] feed_q [$];
  logic [7:0] frame [N];

  logic             core_phase;
  logic [3:0]       core_lo;
  logic [IDX_W-1:0] core_ptr;
  logic [7:0]       core_w [N];

  always #5 clk = ~clk;

  bnn_weight_streamer #(
    .NUM_NEURONS (N),
    .FIFO_DEPTH  (4),
    .IDX_W       (IDX_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .tgt_ena    (tgt_ena),
    .load_en    (load_en),
    .nibble     (nibble),
    .busy       (busy),
    .done       (done),
    .neuron_idx (neuron_idx)
  );

  // Core receiver: low nibble first, then the high nibble writes the byte.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_phase <= 1'b0;
      core_lo    <= 4'h0;
      core_ptr   <= '0;
    end else if (load_en && tgt_ena) begin
      if (!core_phase) begin
        core_lo    <= nibble;
        core_phase <= 1'b1;
      end else begin
        core_w[core_ptr] <= {nibble, core_lo};
        core_phase       <= 1'b0;
        core_ptr         <= (core_ptr == 5'(N-1)) ? '0 : core_ptr + 5'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed nibble must be the next expected {index, nibble}.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (core_phase) check("load_en held between nibbles", 32'(load_en), 1);
        if (load_en && tgt_ena) begin
          if (exp_q.size() == 0) begin
            check("unexpected nibble", 32'({neuron_idx, nibble}), 32'h1FF);
          end else begin
            e = exp_q.pop_front();
            check("idx/nibble", 32'({neuron_idx, nibble}), 32'(e));
          end
        end
      end
    end
  end

  // Feeder: presents the next queued byte only when it will be accepted.
  initial begin
    s_valid = 1'b0;
    s_data  = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (reset === 1'b0 && feed_q.size() > 0 && s_ready) begin
        s_valid = 1'b1;
        s_data  = feed_q.pop_front();
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic enqueue(input logic [7:0] tbl [N], input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      feed_q.push_back(tbl[i]);
      exp_q.push_back({5'(i), tbl[i][3:0]});
      exp_q.push_back({5'(i), tbl[i][7:4]});
      frame[i] = tbl[i];
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
    check({name, " done seen"}, 32'(found), 1);
    if (found) begin
      check({name, " idx at done"}, 32'(neuron_idx), N-1);
      check({name, " load_en at done"}, 32'(load_en), 0);
      @(negedge clk);
      check({name, " done one cycle"}, 32'(done), 0);
      check({name, " busy after done"}, 32'(busy), 0);
    end
  endtask

  task automatic check_frame(input string name);
    for (int i = 0; i < N; i++)
      check($sformatf("%s core_w[%0d]", name, i), 32'(core_w[i]), 32'(frame[i]));
    check({name, " scoreboard drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int  cnt;
    bit  hit;
    reset   = 1'b1;
    start   = 1'b0;
    tgt_ena = 1'b0;
    repeat (2) @(negedge clk);
    check("reset load_en", 32'(load_en), 0);
    check("reset nibble", 32'(nibble), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset neuron_idx", 32'(neuron_idx), 0);
    check("reset s_ready", 32'(s_ready), 1);
    step();
    reset   = 1'b0;
    tgt_ena = 1'b1;

    // A: four pre-filled bytes, then starvation, then the rest of the frame.
    enqueue(TBL_A, 0, 3);
    repeat (6) step();
    @(negedge clk);
    check("A s_ready at full", 32'(s_ready), 0);
    step();
    pulse_start();
    @(negedge clk);
    check("A load_en after start", 32'(load_en), 1);
    check("A busy", 32'(busy), 1);
    cnt = 0;
    while (load_en === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("A load_en run", cnt, 8);
    check("A waiting busy", 32'(busy), 1);
    check("A waiting idx", 32'(neuron_idx), 4);
    enqueue(TBL_A, 4, N-1);
    wait_done("A");
    check_frame("A");

    // B: full frame of the default image with the FIFO kept ahead.
    enqueue(DEFAULT_WEIGHTS, 0, N-1);
    repeat (6) step();
    pulse_start();
    @(negedge clk);
    check("B load_en after start", 32'(load_en), 1);
    cnt = 0;
    while (load_en === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("B load_en run", cnt, 2*N);
    check("B done after run", 32'(done), 1);
    check("B busy at done", 32'(busy), 1);
    @(negedge clk);
    check("B done one cycle", 32'(done), 0);
    check("B busy falls", 32'(busy), 0);
    check_frame("B");

    // C: core disabled for 3 cycles in the high phase of neuron 5 (0x96).
    enqueue(TBL_C, 0, N-1);
    repeat (6) step();
    pulse_start();
    hit = 0;
    for (int t = 0; t < 60; t++) begin
      step();
      if (neuron_idx == 5 && load_en && nibble == 4'h9) begin
        hit = 1;
        break;
      end
    end
    check("C reached neuron 5 hi", 32'(hit), 1);
    tgt_ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("C held nibble", 32'(nibble), 4'h9);
      check("C held load_en", 32'(load_en), 1);
      check("C held idx", 32'(neuron_idx), 5);
    end
    step();
    tgt_ena = 1'b1;
    @(negedge clk);
    check("C idx before consume", 32'(neuron_idx), 5);
    @(negedge clk);
    check("C idx after consume", 32'(neuron_idx), 6);
    wait_done("C");
    check_frame("C");

    // D: FIFO starved after byte 2, then 0x81 arrives five cycles later.
    enqueue(TBL_D, 0, 2);
    repeat (5) step();
    pulse_start();
    hit = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!load_en) begin
        hit = 1;
        break;
      end
    end
    check("D starved", 32'(hit), 1);
    check("D wait load_en", 32'(load_en), 0);
    check("D wait busy", 32'(busy), 1);
    check("D wait idx", 32'(neuron_idx), 3);
    repeat (5) step();
    enqueue(TBL_D, 3, 3);
    hit = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (load_en) begin
        hit = 1;
        break;
      end
    end
    check("D resume", 32'(hit), 1);
    check("D resume nibble lo", 32'(nibble), 4'h1);
    check("D resume idx", 32'(neuron_idx), 3);
    @(negedge clk);
    check("D resume nibble hi", 32'(nibble), 4'h8);
    enqueue(TBL_D, 4, N-1);
    wait_done("D");
    check_frame("D");

    // E: reset in the high phase of neuron 7, then a clean frame.
    enqueue(TBL_E, 0, N-1);
    repeat (6) step();
    pulse_start();
    hit = 0;
    for (int t = 0; t < 60; t++) begin
      step();
      if (neuron_idx == 7 && core_phase && load_en) begin
        hit = 1;
        break;
      end
    end
    check("E reached neuron 7 hi", 32'(hit), 1);
    reset = 1'b1;
    feed_q.delete();
    exp_q.delete();
    #1;
    check("E reset load_en", 32'(load_en), 0);
    check("E reset idx", 32'(neuron_idx), 0);
    check("E reset busy", 32'(busy), 0);
    check("E reset s_ready", 32'(s_ready), 1);
    step();
    reset = 1'b0;
    step();
    pulse_start();
    repeat (3) step();
    @(negedge clk);
    check("E fifo empty after reset", 32'(load_en), 0);
    check("E waiting busy", 32'(busy), 1);
    enqueue(TBL_E, 0, N-1);
    wait_done("E");
    check_frame("E");

    // F: start while busy, FIFO filled to depth while the core is disabled.
    tgt_ena = 1'b0;
    enqueue(TBL_F, 0, N-1);
    repeat (2) step();
    pulse_start();
    repeat (8) step();
    @(negedge clk);
    check("F s_ready full", 32'(s_ready), 0);
    check("F held load_en", 32'(load_en), 1);
    check("F held nibble", 32'(nibble), 4'hD);
    step();
    pulse_start();
    @(negedge clk);
    check("F start ignored idx", 32'(neuron_idx), 0);
    check("F start ignored nibble", 32'(nibble), 4'hD);
    step();
    tgt_ena = 1'b1;
    hit = 0;
    for (int t = 0; t < 40; t++) begin
      step();
      if (neuron_idx == 3) begin
        hit = 1;
        break;
      end
    end
    check("F reached neuron 3", 32'(hit), 1);
    pulse_start();
    @(negedge clk);
    check("F start ignored mid-frame", 32'(neuron_idx >= 3), 1);
    wait_done("F");
    check_frame("F");
    check("F feed drained", feed_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
